// File: rtl/sevenseg_scan.sv
// Time-multiplexed driver for a common-anode seven-segment display: refresh
// prescaler, digit scan, ghost blanking, leading-zero blanking, BCD decode.
package packs;
  typedef struct packed {
    logic [3:0] digito;
    logic       dp;
  } BCDnumber_t;
endpackage

module sevenseg_scan #(
  parameter int DEC          = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int LZB          = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  packs::BCDnumber_t [DEC-1:0] digit,
  output logic [DEC-1:0]             an,
  output logic [6:0]                 seg,
  output logic                       dp_n
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DEC - 1);

  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic              w_blank_phase;
  logic [DEC-1:0]    w_an;
  logic [DEC-1:0]    w_lz;
  logic              w_cur_lz;
  packs::BCDnumber_t w_cur;
  logic [6:0]        w_seg;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Ghost phase at the start of every slot; absent entirely when BLANK_CYCLES is 0.
  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
      assign w_blank_phase = (r_cnt < CNT_BLANK);
    end else begin : g_no_blank
      assign w_blank_phase = 1'b0;
    end
  endgenerate

  // Digit i blanks only if it and every more significant digit are zero.
  always_comb begin
    logic v_run;
    v_run = 1'b1;
    w_lz  = '0;
    for (int i = DEC - 1; i >= 1; i--) begin
      v_run   = v_run & (digit[i].digito == 4'd0);
      w_lz[i] = v_run & (LZB != 0);
    end
  end

  always_comb begin
    w_cur    = digit[0];
    w_cur_lz = 1'b0;
    w_an     = '1;
    for (int i = 0; i < DEC; i++) begin
      if (r_idx == IW'(i)) begin
        w_cur    = digit[i];
        w_cur_lz = w_lz[i];
        w_an[i]  = 1'b0;
      end
    end
    w_seg = w_cur_lz ? 7'h7F : decode(w_cur.digito);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      an    <= '1;
      seg   <= 7'h7F;
      dp_n  <= 1'b1;
    end else begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_blank_phase) begin
        an   <= '1;
        seg  <= 7'h7F;
        dp_n <= 1'b1;
      end else begin
        an   <= w_an;
        seg  <= w_seg;
        dp_n <= ~w_cur.dp;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: three instances (ghost/no-LZB, no-ghost/LZB, single digit)
// compared every cycle against a slot/phase arithmetic model plus spec tables.
module tb_sevenseg_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] dig_v [4];
  logic       dp_v  [4];
  logic [3:0] dig_c;
  logic       dp_c;

  packs::BCDnumber_t [3:0] dig_pk;
  packs::BCDnumber_t [0:0] dig_c_pk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dig_pk[i].digito = dig_v[i];
      dig_pk[i].dp     = dp_v[i];
    end
    dig_c_pk[0].digito = dig_c;
    dig_c_pk[0].dp     = dp_c;
  end

  logic [3:0] a_an, b_an;
  logic [0:0] c_an;
  logic [6:0] a_seg, b_seg, c_seg;
  logic       a_dpn, b_dpn, c_dpn;

  sevenseg_scan #(.DEC(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .LZB(0)) u_a (
    .clk(clk), .rst(rst), .digit(dig_pk), .an(a_an), .seg(a_seg), .dp_n(a_dpn));
  sevenseg_scan #(.DEC(4), .REFRESH_DIV(3), .BLANK_CYCLES(0), .LZB(1)) u_b (
    .clk(clk), .rst(rst), .digit(dig_pk), .an(b_an), .seg(b_seg), .dp_n(b_dpn));
  sevenseg_scan #(.DEC(1), .REFRESH_DIV(2), .BLANK_CYCLES(0), .LZB(1)) u_c (
    .clk(clk), .rst(rst), .digit(dig_c_pk), .an(c_an), .seg(c_seg), .dp_n(c_dpn));

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
  localparam logic [3:0] AN_SEQ [16] = '{
    4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
    4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

  typedef struct {
    logic [3:0] d;
    logic       dp;
    logic [6:0] seg;
    logic       dpn;
  } dec_vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [6:0] b_seen [4];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output after the k-th edge since release reflects scan position c = k-1.
  function automatic logic [11:0] model(input int c, input int ndec, input int rd,
                                        input int bc, input bit lzb,
                                        input logic [15:0] dv, input logic [3:0] dpv);
    int slot, ph;
    logic [3:0] m_an;
    logic [3:0] d;
    bit blank;
    slot = (c / rd) % ndec;
    ph   = c % rd;
    if (ph < bc) return {4'hF, 7'h7F, 1'b1};
    m_an       = 4'hF;
    m_an[slot] = 1'b0;
    d          = dv[slot*4 +: 4];
    blank      = lzb && (slot >= 1);
    for (int j = slot; j < ndec; j++)
      if (dv[j*4 +: 4] != 4'd0) blank = 1'b0;
    return {m_an, blank ? 7'h7F : SEG_TAB[d], ~dpv[slot]};
  endfunction

  function automatic logic [15:0] dv_pk();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = dig_v[i];
    return r;
  endfunction

  function automatic logic [3:0] dp_pk();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = dp_v[i];
    return r;
  endfunction

  task automatic tick();
    int c;
    logic [3:0] onehot;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    c = cyc - 1;
    chk("model_a", {28'h0, a_an, a_seg, a_dpn}, {28'h0, model(c, 4, 4, 1, 1'b0, dv_pk(), dp_pk())});
    chk("model_b", {28'h0, b_an, b_seg, b_dpn}, {28'h0, model(c, 4, 3, 0, 1'b1, dv_pk(), dp_pk())});
    chk("model_c", {28'h0, 3'b111, c_an, c_seg, c_dpn},
        {28'h0, model(c, 1, 2, 0, 1'b1, {12'h0, dig_c}, {3'b000, dp_c})});
    for (int s = 0; s < 4; s++) begin
      onehot = 4'b0001 << s;
      if (b_an == ~onehot) b_seen[s] = b_seg;
    end
  endtask

  task automatic lzb_frame(input string name, input logic [15:0] dv, input logic [27:0] exp);
    for (int i = 0; i < 4; i++) begin
      dig_v[i]  = dv[i*4 +: 4];
      b_seen[i] = 7'bx;
    end
    repeat (12) tick();
    for (int s = 0; s < 4; s++)
      chk($sformatf("%s_slot%0d", name, s), {33'h0, b_seen[s]}, {33'h0, exp[s*7 +: 7]});
  endtask

  always @(negedge clk) begin
    checks++;
    if ($countones(~a_an) > 1 || $countones(~b_an) > 1) begin
      errors++;
      $display("FAIL no_overlap: a_an=%b b_an=%b (cycle %0d)", a_an, b_an, cyc);
    end
  end

  dec_vec_t vecs [16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i].d   = 4'(i);
      vecs[i].dp  = 1'(i % 2);
      vecs[i].seg = SEG_TAB[i];
      vecs[i].dpn = ~vecs[i].dp;
    end

    rst = 1'b0;
    dig_v[3] = 4'd9; dig_v[2] = 4'd5; dig_v[1] = 4'd9; dig_v[0] = 4'd9;
    dp_v[3] = 1'b1;  dp_v[2] = 1'b0;  dp_v[1] = 1'b1;  dp_v[0] = 1'b0;
    dig_c = 4'd0; dp_c = 1'b0;
    #12;
    chk("reset_state", {7'h0, a_an, a_seg, a_dpn, b_an, b_seg, b_dpn, c_an, c_seg, c_dpn},
        {7'h0, 33'h1_FFFF_FFFF});
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;

    // Anode scan pattern and decimal-point placement over one frame of u_a.
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("an_seq", {36'h0, a_an}, {36'h0, AN_SEQ[i]});
      chk("dp_seq", {39'h0, a_dpn}, {39'h0, !(AN_SEQ[i] == 4'hD || AN_SEQ[i] == 4'h7)});
    end

    for (int i = 0; i < 16; i++) begin
      dig_c = vecs[i].d;
      dp_c  = vecs[i].dp;
      tick();
      chk("decode", {31'h0, c_an, c_seg, c_dpn}, {31'h0, 1'b0, vecs[i].seg, vecs[i].dpn});
    end

    lzb_frame("lzb_0007", 16'h0007, {7'h7F, 7'h7F, 7'h7F, 7'b1111000});
    lzb_frame("lzb_0000", 16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'b1000000});
    lzb_frame("lzb_0C03", 16'h0C03, {7'h7F, 7'b0111111, 7'b1000000, 7'b0110000});

    repeat (300) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < 4; i++) begin
          dig_v[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
          dp_v[i]  = 1'($urandom_range(0, 1));
        end
      end
      dig_c = 4'($urandom_range(0, 15));
      dp_c  = 1'($urandom_range(0, 1));
      tick();
    end

    // Live update in the middle of slot 0 of u_a.
    dig_v[3] = 4'd9; dig_v[2] = 4'd5; dig_v[1] = 4'd9; dig_v[0] = 4'd3;
    for (int n = 0; n < 16 && (cyc % 16) != 2; n++) tick();
    chk("live_before", {29'h0, a_an, a_seg}, {29'h0, 4'b1110, 7'b0110000});
    dig_v[0] = 4'd4;
    tick();
    chk("live_after", {29'h0, a_an, a_seg}, {29'h0, 4'b1110, 7'b0011001});

    // Asynchronous reset while u_a drives digit 2.
    for (int n = 0; n < 16 && (cyc % 16) != 10; n++) tick();
    chk("pre_reset_an", {36'h0, a_an}, {36'h0, 4'b1011});
    #2 rst = 1'b0;
    #1;
    chk("async_reset", {7'h0, a_an, a_seg, a_dpn, b_an, b_seg, b_dpn, c_an, c_seg, c_dpn},
        {7'h0, 33'h1_FFFF_FFFF});
    @(negedge clk);
    chk("reset_hold", {28'h0, a_an, a_seg, a_dpn}, {28'h0, 12'hFFF});
    rst = 1'b1;
    cyc = 0;
    tick();
    chk("post_reset_blank", {36'h0, a_an}, {36'h0, 4'hF});
    tick();
    chk("post_reset_first", {36'h0, a_an}, {36'h0, 4'b1110});

    repeat (48) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
- Downstream consumer of the stopwatch digit vector. It time-multiplexes DEC BCD digits (each with a decimal-point flag) onto one common-anode seven-segment bus.
- Contains a refresh prescaler, a digit scan counter, inter-digit ghost blanking, optional leading-zero blanking and the BCD-to-segment decoder.
- All outputs are registered and drive board pins directly.

Parameters:
- DEC, 4: number of digits scanned; must match the stopwatch DEC.
- REFRESH_DIV, 50000: clk cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must satisfy 0 <= BLANK_CYCLES < REFRESH_DIV.
- LZB, 1: 1 enables leading-zero blanking; 0 disables it.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- digit, input, DEC x packs::BCDnumber_t (.digito[3:0], .dp): digit values; index 0 is least significant.
- an, output, DEC: anode enables, active-low, one-hot-low or all-high.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- dp_n, output, 1: decimal point, active-low.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release by design): cnt=0, idx=0, an='1, seg=7'h7F, dp_n=1.
- Prescaler cnt:
  - Counts 0..REFRESH_DIV-1 every clk and wraps to 0.
  - When cnt==REFRESH_DIV-1, idx advances: idx+1, wrapping from DEC-1 to 0.
  - No enable; scanning runs continuously.
- Output register: one-cycle latency from (cnt, idx, digit) to (an, seg, dp_n).
  - If cnt < BLANK_CYCLES: an='1 and seg/dp_n are don't-care (driven to all-high).
  - Otherwise: an=~(1<<idx), seg=decode(digit[idx]), dp_n=~digit[idx].dp.
  - Inputs are sampled every cycle, not snapshotted per slot. A digit change mid-slot is visible on the next cycle.
- Decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15: dash = 0111111
- Leading-zero blanking (LZB=1):
  - Digit i (i>=1) is blank when digito==0 for every j in [i, DEC-1]. Its seg is then 1111111.
  - Digit 0 is never blanked.
  - dp_n still follows digit[i].dp on a blanked digit.
  - An invalid code (>9) is not zero, so it stops blanking below it.
- Slot period is REFRESH_DIV cycles and a full frame is DEC*REFRESH_DIV cycles. an is never low on two digits at once.
- Reset mid-slot: outputs go high immediately, not waiting for clk. After release, the scan restarts at digit 0 with a blank phase.
- BLANK_CYCLES=0: no ghost phase. an switches directly between adjacent digits on the cycle after the idx change.

Test Plan:
- Reset: DEC=4, REFRESH_DIV=4, BLANK_CYCLES=1, LZB=0, digit={9,5,9,9}. Hold rst=0 -> an=1111, seg=1111111, dp_n=1. Release -> an pattern repeats every 16 cycles:
  - 1111, then 1110 x3
  - 1111, then 1101 x3
  - 1111, then 1011 x3
  - 1111, then 0111 x3
- Decode sweep: DEC=1, BLANK_CYCLES=0, digito stepped 0..15 -> seg matches the table one cycle later. Codes 10..15 -> 0111111.
- Decimal point: digits 1 and 3 have .dp=1 (stopwatch pattern), digits 0 and 2 have .dp=0 -> dp_n=0 only while an=1101 or 0111.
- Leading-zero blanking: LZB=1, digito={0,0,0,7} (index 3..0):
  - Slots 3, 2, 1 -> seg=1111111.
  - Slot 0 -> 1111000.
  - digito={0,0,0,0} -> only slot 0 shows 1000000.
  - digito={0,12,0,3} -> slot 3 blank, slot 2 dash, slot 1 shows 0.
- Asynchronous reset mid-slot: assert rst=0 between clk edges during an=1011 -> an=1111 before the next edge. After release, the first active anode is 1110 after BLANK_CYCLES+1 cycles.
- Live update and no-overlap: change digit[0] from 3 to 4 mid-slot -> seg changes on the next cycle. A checker asserts popcount(~an) <= 1 every cycle over 3 frames.
